// File: rtl/serial_mag_cmp_pkg.sv
// serial_mag_cmp_pkg: shared state encoding, result bit positions and counter sizing
package serial_mag_cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int R_EQ = 0;
  localparam int R_GT = 1;
  localparam int R_LT = 2;
  localparam int R_NE = 3;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/serial_mag_cmp_digit_cmp.sv
// digit_cmp: combinational DIGIT-bit unsigned compare cell
module digit_cmp #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             d_eq,
  output logic             d_gt,
  output logic             d_lt
);
  assign d_eq = a == b;
  assign d_gt = a > b;
  assign d_lt = a < b;
endmodule

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: MSB-first bit-serial magnitude comparator, optional SERIAL_MAG_CMP_EARLY_EXIT_EN
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             ne
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("serial_mag_cmp: DIGIT must divide WIDTH exactly");
  end
  state_t           st;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             dgt, dlt, c_eq, c_gt, c_lt, ng, nl, fin;
  logic [3:0]       res;
  digit_cmp #(.DIGIT(DIGIT)) u_cmp (
    .a    (sa[WIDTH-1 -: DIGIT]),
    .b    (sb[WIDTH-1 -: DIGIT]),
    .d_eq (c_eq),
    .d_gt (c_gt),
    .d_lt (c_lt)
  );
  assign ng  = dgt | (~dlt & c_gt);
  assign nl  = dlt | (~dgt & c_lt);
  assign fin = (cnt == CW'(N - 1)) | (EARLY_EXIT & ~c_eq);
  assign eq  = res[R_EQ];
  assign gt  = res[R_GT];
  assign lt  = res[R_LT];
  assign ne  = res[R_NE];
  // control FSM: capture on start, shift one digit per RUN cycle, latch results entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      sa   <= '0;
      sb   <= '0;
      cnt  <= '0;
      dgt  <= 1'b0;
      dlt  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      res  <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          sa   <= a;
          sb   <= b;
          cnt  <= '0;
          dgt  <= 1'b0;
          dlt  <= 1'b0;
          busy <= 1'b1;
          st   <= RUN;
        end
        RUN: begin
          sa  <= sa << DIGIT;
          sb  <= sb << DIGIT;
          cnt <= cnt + 1'b1;
          dgt <= ng;
          dlt <= nl;
          if (fin) begin
            st        <= DONE;
            done      <= 1'b1;
            res[R_EQ] <= ~(ng | nl);
            res[R_GT] <= ng;
            res[R_LT] <= nl;
            res[R_NE] <= ng | nl;
          end
        end
        DONE: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp: randomized self-checking bench for 8x1 and 16x4 comparator builds
module tb_serial_mag_cmp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0, start16 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy8, done8, eq8, gt8, lt8, ne8;
  logic busy16, done16, eq16, gt16, lt16, ne16;
  logic [5:0] o8, o16;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8), .ne(ne8)
  );
  serial_mag_cmp #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .eq(eq16), .gt(gt16), .lt(lt16), .ne(ne16)
  );

  assign o8  = {busy8, done8, eq8, gt8, lt8, ne8};
  assign o16 = {busy16, done16, eq16, gt16, lt16, ne16};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // latency in RUN edges: index of first differing digit with early exit, otherwise all digits
  function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y, input int w, input int d);
    logic [15:0] m;
    int n;
    n = w / d;
    m = (16'h1 << d) - 16'h1;
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
    for (int i = 0; i < n; i++)
      if (((x >> (w - d * (i + 1))) & m) != ((y >> (w - d * (i + 1))) & m)) return i + 1;
`endif
    return n;
  endfunction

  // one full compare starting at a negedge; returns at the negedge of the following IDLE cycle
  task automatic cmp(input bit s, input logic [15:0] x, input logic [15:0] y, input bit hold, input string tag);
    logic [5:0] o;
    logic [3:0] er;
    logic [15:0] ex, ey;
    int lat, w, d;
    w  = s ? 16 : 8;
    d  = s ? 4 : 1;
    ex = s ? x : {8'h00, x[7:0]};
    ey = s ? y : {8'h00, y[7:0]};
    er = {ex == ey, ex > ey, ex < ey, ex != ey};
    if (s) begin start16 = 1'b1; a16 = x; b16 = y; end
    else begin start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; end
    @(posedge clk);
    #1;
    if (s) begin start16 = hold; a16 = 16'($urandom); b16 = 16'($urandom); end
    else begin start8 = hold; a8 = 8'($urandom); b8 = 8'($urandom); end
    @(negedge clk);
    o = s ? o16 : o8;
    check({tag, "_busy_run"}, 32'(o[5:4]), 32'b10);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      o = s ? o16 : o8;
      if (hold) begin
        if (s) begin a16 = 16'($urandom); b16 = 16'($urandom); end
        else begin a8 = 8'($urandom); b8 = 8'($urandom); end
      end
      if (o[4]) begin lat = k; break; end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(ex, ey, w, d)));
    check({tag, "_res"}, 32'(o[3:0]), 32'(er));
    check({tag, "_busy_done"}, 32'(o[5]), 32'b1);
    @(posedge clk);
    #1;
    if (s) start16 = 1'b0; else start8 = 1'b0;
    @(negedge clk);
    o = s ? o16 : o8;
    check({tag, "_idle"}, 32'(o), 32'({2'b00, er}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] x, y;
    bit s, quiet;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset8", 32'(o8), 32'h0);
    check("reset16", 32'(o16), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    cmp(1'b0, 16'h00A5, 16'h00A5, 1'b0, "eq_a5");
    cmp(1'b0, 16'h0080, 16'h007F, 1'b0, "gt_msb");
    cmp(1'b0, 16'h0012, 16'h0013, 1'b0, "lt_lsb");
    cmp(1'b1, 16'hFFFF, 16'h0000, 1'b0, "b2b_gt");
    cmp(1'b1, 16'h0000, 16'hFFFF, 1'b0, "b2b_lt");
    cmp(1'b1, 16'h1234, 16'h1235, 1'b0, "w16_lsd");
    cmp(1'b0, 16'h003C, 16'h00C3, 1'b1, "hold_start");
    cmp(1'b0, 16'h00FF, 16'h00FE, 1'b0, "after_hold");
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h13;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid8", 32'(o8), 32'h0);
    check("rst_mid16", 32'(o16), 32'h0);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) quiet = 1'b0;
    end
    check("rst_no_done", 32'(quiet), 32'h1);
    cmp(1'b0, 16'h0040, 16'h0041, 1'b0, "post_rst");
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ (16'h1 << $urandom_range(0, s ? 15 : 7));
        default: y = 16'($urandom);
      endcase
      cmp(s, x, y, 1'($urandom_range(0, 1)), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
